// File: rtl/mandel_pkg.sv
// Shared constants for the Mandelbrot tile scheduler.
// Holds the command length, the byte position of each command field and
// the state encoding used by the tile walker in mandel_tile_sched.
package mandel_pkg;

  localparam int CMD_BYTES = 10;

  // Byte positions inside the tile command as received over the UART
  localparam int IDX_PIX_X = 0;
  localparam int IDX_PIX_Y = 1;
  localparam int IDX_CXS_H = 2;
  localparam int IDX_CXS_L = 3;
  localparam int IDX_CYS_H = 4;
  localparam int IDX_CYS_L = 5;
  localparam int IDX_DCX_H = 6;
  localparam int IDX_DCX_L = 7;
  localparam int IDX_DCY_H = 8;
  localparam int IDX_DCY_L = 9;

  // Tile walker states
  localparam logic [2:0] ST_RECV  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_SEND  = 3'd4;
  localparam logic [2:0] ST_NEXT  = 3'd5;

  // Joins a big-endian byte pair into one 16-bit field
  function automatic logic [15:0] be16(input logic [7:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/mandel_cmd_rx.sv
// Tile command assembler.
// Collects the 10-byte tile command from the UART receiver and exposes its
// fields. A partially received command is dropped after RX_TO idle cycles so
// a lost byte cannot permanently misalign the stream.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   rx_data/rx_valid received byte and its one-cycle strobe
//   enable           bytes are only accepted while high (scheduler idle)
//   cmd_valid        combinational pulse in the cycle the 10th byte arrives
//   pix_x, pix_y     tile dimensions in pixels
//   cxs, cys         start coordinates (CW bits, sign-extended or truncated)
//   dcx, dcy         per-pixel coordinate steps (same format)
module mandel_cmd_rx
  import mandel_pkg::*;
#(
  parameter int CW    = 16,
  parameter int RX_TO = 520
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic          enable,
  output logic          cmd_valid,
  output logic [7:0]    pix_x,
  output logic [7:0]    pix_y,
  output logic [CW-1:0] cxs,
  output logic [CW-1:0] cys,
  output logic [CW-1:0] dcx,
  output logic [CW-1:0] dcy
);

  localparam int TW = $clog2(RX_TO + 1);

  logic [3:0]    idx;
  logic [TW-1:0] idle;
  logic [7:0]    cmd_bytes [CMD_BYTES];
  logic          take;

  assign take      = rx_valid && enable;
  assign cmd_valid = take && (idx == 4'(CMD_BYTES - 1));

  // Byte index and idle timer; the timer saturates at RX_TO so a long idle
  // period keeps the partial-command drop asserted without wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx  <= '0;
      idle <= '0;
    end else if (take) begin
      idle <= '0;
      idx  <= cmd_valid ? 4'd0 : idx + 4'd1;
    end else begin
      if (idle != TW'(RX_TO))
        idle <= idle + 1'b1;
      if (idle >= TW'(RX_TO) && idx != 4'd0)
        idx <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CMD_BYTES; i++)
        cmd_bytes[i] <= '0;
    end else if (take) begin
      cmd_bytes[idx] <= rx_data;
    end
  end

  // A signed size cast sign-extends for CW>16 and keeps the LSBs for CW<16
  assign pix_x = cmd_bytes[IDX_PIX_X];
  assign pix_y = cmd_bytes[IDX_PIX_Y];
  assign cxs   = CW'($signed(be16(cmd_bytes[IDX_CXS_H], cmd_bytes[IDX_CXS_L])));
  assign cys   = CW'($signed(be16(cmd_bytes[IDX_CYS_H], cmd_bytes[IDX_CYS_L])));
  assign dcx   = CW'($signed(be16(cmd_bytes[IDX_DCX_H], cmd_bytes[IDX_DCX_L])));
  assign dcy   = CW'($signed(be16(cmd_bytes[IDX_DCY_H], cmd_bytes[IDX_DCY_L])));

endmodule

// File: rtl/mandel_tile_sched.sv
// Tile scheduler between the UART byte link and the Mandelbrot pixel engine.
// Walks a received tile row-major, starts the engine once per pixel and
// returns each pixel's iteration count (saturated to 8 bits) as one TX byte.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   rx_data, rx_valid    incoming command bytes
//   eng_start            one-cycle engine start pulse
//   eng_cx, eng_cy       coordinates of the current pixel, stable until eng_done
//   eng_done, eng_count  engine completion strobe and iteration count
//   tx_data, tx_valid    outgoing byte, valid held until tx_ready
//   tx_ready             transmitter accepts the byte
//   busy                 a tile is being processed
module mandel_tile_sched
  import mandel_pkg::*;
#(
  parameter int CW    = 16,
  parameter int ITW   = 8,
  parameter int RX_TO = 520
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     rx_data,
  input  logic           rx_valid,
  output logic           eng_start,
  output logic [CW-1:0]  eng_cx,
  output logic [CW-1:0]  eng_cy,
  input  logic           eng_done,
  input  logic [ITW-1:0] eng_count,
  output logic [7:0]     tx_data,
  output logic           tx_valid,
  input  logic           tx_ready,
  output logic           busy
);

  logic [2:0]    state;
  logic [7:0]    ix;
  logic [7:0]    iy;
  logic [CW-1:0] cx;
  logic [CW-1:0] cy;
  logic          cmd_valid;
  logic [7:0]    pix_x;
  logic [7:0]    pix_y;
  logic [CW-1:0] cxs;
  logic [CW-1:0] cys;
  logic [CW-1:0] dcx;
  logic [CW-1:0] dcy;
  logic [7:0]    sat_count;

  mandel_cmd_rx #(
    .CW    (CW),
    .RX_TO (RX_TO)
  ) u_cmd_rx (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .enable    (state == ST_RECV),
    .cmd_valid (cmd_valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .cxs       (cxs),
    .cys       (cys),
    .dcx       (dcx),
    .dcy       (dcy)
  );

  // Counts wider than a byte clamp to 0xFF; narrower ones are zero-extended
  generate
    if (ITW > 8) begin : g_sat
      assign sat_count = (eng_count > ITW'(255)) ? 8'hFF : eng_count[7:0];
    end else begin : g_zext
      assign sat_count = 8'(eng_count);
    end
  endgenerate

  // Tile walker. The coordinate accumulators wrap modulo 2^CW on purpose;
  // the command receiver is only enabled in RECV, so bytes arriving during
  // a tile never disturb the fields being walked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_RECV;
      ix       <= '0;
      iy       <= '0;
      cx       <= '0;
      cy       <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else begin
      case (state)
        ST_RECV: begin
          if (cmd_valid)
            state <= ST_LOAD;
        end
        ST_LOAD: begin
          ix    <= '0;
          iy    <= '0;
          cx    <= cxs;
          cy    <= cys;
          state <= (pix_x == 8'd0 || pix_y == 8'd0) ? ST_RECV : ST_ISSUE;
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (eng_done) begin
            tx_data  <= sat_count;
            tx_valid <= 1'b1;
            state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (ix < pix_x - 8'd1) begin
            ix    <= ix + 8'd1;
            cx    <= cx + dcx;
            state <= ST_ISSUE;
          end else begin
            ix    <= '0;
            cx    <= cxs;
            iy    <= iy + 8'd1;
            cy    <= cy + dcy;
            state <= (iy == pix_y - 8'd1) ? ST_RECV : ST_ISSUE;
          end
        end
        default: state <= ST_RECV;
      endcase
    end
  end

  assign eng_start = (state == ST_ISSUE);
  assign eng_cx    = cx;
  assign eng_cy    = cy;
  assign busy      = (state != ST_RECV);

endmodule

// File: tb/tb_mandel_tile_sched.sv
// Self-checking bench for mandel_tile_sched (CW=16, ITW=10).
// A bench-side engine and UART TX model serve each tile; the expected pixel
// coordinates and TX bytes come from a direct row-major arithmetic model of
// the tile command.
module tb_mandel_tile_sched;

  localparam int CW    = 16;
  localparam int ITW   = 10;
  localparam int RX_TO = 520;

  logic           clk = 1'b0;
  logic           rst;
  logic [7:0]     rx_data;
  logic           rx_valid;
  logic           eng_start;
  logic [CW-1:0]  eng_cx;
  logic [CW-1:0]  eng_cy;
  logic           eng_done;
  logic [ITW-1:0] eng_count;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready;
  logic           busy;

  always #20 clk = ~clk;

  mandel_tile_sched #(
    .CW    (CW),
    .ITW   (ITW),
    .RX_TO (RX_TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .eng_start (eng_start),
    .eng_cx    (eng_cx),
    .eng_cy    (eng_cy),
    .eng_done  (eng_done),
    .eng_count (eng_count),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]  cmd [10];
  logic [15:0] q_cx [$];
  logic [15:0] q_cy [$];
  logic [7:0]  q_tx [$];
  int          q_cnt [$];
  logic [15:0] e_cx [$];
  logic [15:0] e_cy [$];
  logic [7:0]  e_tx [$];
  int n_stable_err, n_extra_start, n_timeout, n_lat_err, first_lat;

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_cmd();
    for (int i = 0; i < 10; i++) send_byte(cmd[i]);
  endtask

  // Expected tile: row-major walk, coordinates modulo 2^16, counts clamped to 255
  function automatic void model_tile();
    int px, py;
    logic [15:0] sx, sy, stx, sty;
    px  = cmd[0];
    py  = cmd[1];
    sx  = {cmd[2], cmd[3]};
    sy  = {cmd[4], cmd[5]};
    stx = {cmd[6], cmd[7]};
    sty = {cmd[8], cmd[9]};
    e_cx.delete(); e_cy.delete(); e_tx.delete();
    for (int y = 0; y < py; y++)
      for (int x = 0; x < px; x++) begin
        e_cx.push_back(16'(sx + x * stx));
        e_cy.push_back(16'(sy + y * sty));
      end
    foreach (q_cnt[i]) e_tx.push_back(q_cnt[i] > 255 ? 8'hFF : 8'(q_cnt[i]));
  endfunction

  // Sends the command in cmd[] and plays engine + transmitter until busy drops.
  // Start latency is counted in negedges after the last byte / tx transfer;
  // one negedge step here equals two clocks after the driving cycle.
  // cnt_mode: 0 count=pixel index, 1 random 10-bit, 2 0x3FF then 0x100.
  // junk injects rx bytes during WAIT and eng_done pulses during SEND.
  task automatic serve_tile(input int bp_min, input int bp_max, input int cnt_mode, input bit junk);
    int w, pix, cnt, d, r;
    logic [15:0] hold_cx, hold_cy;
    logic [7:0]  hold_tx;
    q_cx.delete(); q_cy.delete(); q_tx.delete(); q_cnt.delete();
    n_stable_err = 0; n_extra_start = 0; n_timeout = 0; n_lat_err = 0; first_lat = -1; pix = 0;
    send_cmd();
    while (pix < 300) begin
      w = 0;
      while (!eng_start && busy && w < 40) begin @(negedge clk); w++; end
      if (!eng_start) begin
        if (busy) n_timeout++;
        break;
      end
      if (pix == 0) first_lat = w;
      else if (w != 1) n_lat_err++;
      hold_cx = eng_cx;
      hold_cy = eng_cy;
      q_cx.push_back(eng_cx);
      q_cy.push_back(eng_cy);
      case (cnt_mode)
        0:       cnt = pix;
        1:       cnt = int'($urandom_range(0, 1023));
        default: cnt = (pix == 0) ? 'h3FF : 'h100;
      endcase
      q_cnt.push_back(cnt);
      d = int'($urandom_range(1, 4));
      for (int k = 0; k < d; k++) begin
        if (junk) begin rx_data = 8'($urandom); rx_valid = 1'b1; end
        @(negedge clk);
        rx_valid = 1'b0;
        if (eng_start) n_extra_start++;
        if (eng_cx !== hold_cx || eng_cy !== hold_cy) n_stable_err++;
      end
      eng_count = ITW'(cnt);
      eng_done  = 1'b1;
      @(negedge clk);
      eng_done  = 1'b0;
      w = 0;
      while (!tx_valid && w < 10) begin @(negedge clk); w++; end
      if (!tx_valid) begin n_timeout++; break; end
      hold_tx = tx_data;
      q_tx.push_back(tx_data);
      r = int'($urandom_range(bp_min, bp_max));
      for (int k = 0; k < r; k++) begin
        if (junk) begin eng_done = 1'b1; eng_count = ITW'($urandom); end
        @(negedge clk);
        eng_done = 1'b0;
        if (!tx_valid || tx_data !== hold_tx) n_stable_err++;
        if (eng_start) n_extra_start++;
      end
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
      pix++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    total++; if (eng_start !== 1'b0) begin bad++; $display("[TB] FAIL reset_eng_start: got %b want 0", eng_start); end
    total++; if (tx_valid !== 1'b0)  begin bad++; $display("[TB] FAIL reset_tx_valid: got %b want 0", tx_valid); end
    total++; if (busy !== 1'b0)      begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    total++; if (eng_cx !== 16'h0)   begin bad++; $display("[TB] FAIL reset_eng_cx: got %h want 0000", eng_cx); end
    total++; if (eng_cy !== 16'h0)   begin bad++; $display("[TB] FAIL reset_eng_cy: got %h want 0000", eng_cy); end
    total++; if (tx_data !== 8'h0)   begin bad++; $display("[TB] FAIL reset_tx_data: got %h want 00", tx_data); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_tile();
    cmd = '{8'h03, 8'h04, 8'hE0, 8'h00, 8'hF0, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40};
    serve_tile(0, 0, 0, 1'b0);
    model_tile();
    total++; if (q_cx.size() != 12) begin bad++; $display("[TB] FAIL basic_starts: got %0d want 12", q_cx.size()); end
    total++; if (first_lat != 1) begin bad++; $display("[TB] FAIL basic_first_latency: got %0d steps want 1", first_lat); end
    total++; if (n_lat_err != 0 || n_timeout != 0) begin bad++; $display("[TB] FAIL basic_latency: late=%0d timeouts=%0d want 0/0", n_lat_err, n_timeout); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL basic_busy_end: got %b want 0", busy); end
    foreach (q_cx[i]) if (i < e_cx.size()) begin
      total++;
      if (q_cx[i] !== e_cx[i] || q_cy[i] !== e_cy[i] || q_tx[i] !== e_tx[i] || q_tx[i] !== 8'(i)) begin
        bad++;
        $display("[TB] FAIL basic_pixel%0d: got (%h,%h) tx %h want (%h,%h) tx %h", i, q_cx[i], q_cy[i], q_tx[i], e_cx[i], e_cy[i], 8'(i));
      end
    end
  endtask

  task automatic test_backpressure();
    cmd = '{8'h03, 8'h04, 8'hE0, 8'h00, 8'hF0, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40};
    serve_tile(50, 50, 1, 1'b0);
    model_tile();
    total++; if (q_tx.size() != 12) begin bad++; $display("[TB] FAIL bp_bytes: got %0d want 12", q_tx.size()); end
    total++; if (n_stable_err != 0) begin bad++; $display("[TB] FAIL bp_stability: got %0d glitches want 0", n_stable_err); end
    total++; if (n_extra_start != 0) begin bad++; $display("[TB] FAIL bp_extra_start: got %0d want 0", n_extra_start); end
    foreach (q_tx[i]) if (i < e_tx.size()) begin
      total++;
      if (q_tx[i] !== e_tx[i] || q_cx[i] !== e_cx[i] || q_cy[i] !== e_cy[i]) begin
        bad++;
        $display("[TB] FAIL bp_pixel%0d: got (%h,%h) tx %h want (%h,%h) tx %h", i, q_cx[i], q_cy[i], q_tx[i], e_cx[i], e_cy[i], e_tx[i]);
      end
    end
  endtask

  task automatic test_timeout();
    send_byte(8'h05); send_byte(8'h07); send_byte(8'hAA); send_byte(8'h55);
    repeat (RX_TO + 5) @(negedge clk);
    cmd = '{8'h01, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h00, 8'h00, 8'h00};
    serve_tile(0, 2, 1, 1'b0);
    model_tile();
    total++; if (q_cx.size() != 1) begin bad++; $display("[TB] FAIL timeout_starts: got %0d want 1", q_cx.size()); end
    if (q_cx.size() >= 1) begin
      total++;
      if (q_cx[0] !== 16'h1234 || q_cy[0] !== 16'h5678 || q_tx[0] !== e_tx[0]) begin
        bad++;
        $display("[TB] FAIL timeout_pixel: got (%h,%h) tx %h want (1234,5678) tx %h", q_cx[0], q_cy[0], q_tx[0], e_tx[0]);
      end
    end
  endtask

  task automatic test_zero_dim();
    int starts, valids;
    starts = 0; valids = 0;
    cmd = '{8'h00, 8'h03, 8'h11, 8'h11, 8'h22, 8'h22, 8'h00, 8'h10, 8'h00, 8'h10};
    send_cmd();
    repeat (30) begin
      @(negedge clk);
      if (eng_start) starts++;
      if (tx_valid) valids++;
    end
    total++; if (starts != 0 || valids != 0) begin bad++; $display("[TB] FAIL zero_dim_activity: got starts=%0d tx_valid=%0d want 0/0", starts, valids); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL zero_dim_busy: got %b want 0", busy); end
    cmd = '{8'h01, 8'h01, 8'hAB, 8'hCD, 8'h13, 8'h57, 8'h00, 8'h00, 8'h00, 8'h00};
    serve_tile(0, 1, 1, 1'b0);
    model_tile();
    total++;
    if (q_cx.size() != 1 || q_cx[0] !== 16'hABCD || q_cy[0] !== 16'h1357 || q_tx[0] !== e_tx[0]) begin
      bad++;
      $display("[TB] FAIL zero_dim_next: got %0d starts (%h,%h) want 1 at (abcd,1357)", q_cx.size(), eng_cx, eng_cy);
    end
  endtask

  task automatic test_wrap_sat();
    cmd = '{8'h02, 8'h01, 8'h7F, 8'hC0, 8'h00, 8'h10, 8'h00, 8'h40, 8'h00, 8'h00};
    serve_tile(0, 1, 2, 1'b0);
    total++; if (q_cx.size() != 2) begin bad++; $display("[TB] FAIL wrap_starts: got %0d want 2", q_cx.size()); end
    if (q_cx.size() == 2) begin
      total++; if (q_cx[0] !== 16'h7FC0 || q_cx[1] !== 16'h8000) begin bad++; $display("[TB] FAIL wrap_cx: got %h,%h want 7fc0,8000", q_cx[0], q_cx[1]); end
      total++; if (q_tx[0] !== 8'hFF || q_tx[1] !== 8'hFF) begin bad++; $display("[TB] FAIL sat_tx: got %h,%h want ff,ff", q_tx[0], q_tx[1]); end
    end
  endtask

  task automatic test_reset_mid_tile();
    int w;
    cmd = '{8'h02, 8'h02, 8'h40, 8'h00, 8'h40, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00};
    send_cmd();
    w = 0;
    while (!eng_start && w < 20) begin @(negedge clk); w++; end
    total++; if (!eng_start) begin bad++; $display("[TB] FAIL midreset_start: got %b want 1", eng_start); end
    @(negedge clk);
    send_byte(8'h01); send_byte(8'h01); send_byte(8'h99);
    rst = 1'b1;
    #1;
    total++;
    if (eng_start !== 1'b0 || tx_valid !== 1'b0 || busy !== 1'b0 || eng_cx !== 16'h0 || eng_cy !== 16'h0 || tx_data !== 8'h0) begin
      bad++;
      $display("[TB] FAIL midreset_outputs: got start=%b txv=%b busy=%b cx=%h cy=%h tx=%h want all 0", eng_start, tx_valid, busy, eng_cx, eng_cy, tx_data);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cmd = '{8'h01, 8'h02, 8'h01, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10};
    serve_tile(0, 2, 1, 1'b0);
    model_tile();
    total++; if (q_cx.size() != 2) begin bad++; $display("[TB] FAIL midreset_starts: got %0d want 2", q_cx.size()); end
    foreach (q_cx[i]) if (i < e_cx.size()) begin
      total++;
      if (q_cx[i] !== e_cx[i] || q_cy[i] !== e_cy[i] || q_tx[i] !== e_tx[i]) begin
        bad++;
        $display("[TB] FAIL midreset_pixel%0d: got (%h,%h) tx %h want (%h,%h) tx %h", i, q_cx[i], q_cy[i], q_tx[i], e_cx[i], e_cy[i], e_tx[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++) begin
      cmd[0] = 8'($urandom_range(1, 4));
      cmd[1] = 8'($urandom_range(1, 3));
      for (int b = 2; b < 10; b++) cmd[b] = 8'($urandom);
      serve_tile(1, 3, 1, 1'b1);
      model_tile();
      total++;
      if (q_cx.size() != e_cx.size() || n_stable_err != 0 || n_extra_start != 0 || n_timeout != 0 || n_lat_err != 0 || first_lat != 1) begin
        bad++;
        $display("[TB] FAIL b2b%0d_flow: got starts=%0d glitch=%0d extra=%0d to=%0d late=%0d lat=%0d want starts=%0d rest 0, lat 1",
                 n, q_cx.size(), n_stable_err, n_extra_start, n_timeout, n_lat_err, first_lat, e_cx.size());
      end
      foreach (q_cx[i]) if (i < e_cx.size()) begin
        total++;
        if (q_cx[i] !== e_cx[i] || q_cy[i] !== e_cy[i] || q_tx[i] !== e_tx[i]) begin
          bad++;
          $display("[TB] FAIL b2b%0d_pixel%0d: got (%h,%h) tx %h want (%h,%h) tx %h", n, i, q_cx[i], q_cy[i], q_tx[i], e_cx[i], e_cy[i], e_tx[i]);
        end
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    eng_done  = 1'b0;
    eng_count = '0;
    tx_ready  = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic_tile();
    test_backpressure();
    test_timeout();
    test_zero_dim();
    test_wrap_sat();
    test_reset_mid_tile();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
